tcdm_req_arbiter: RTL and testbench

TCDM_REQ_ARBITER -- requirements
Module: tcdm_req_arbiter

---
 rtl/tcdm_req_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_tcdm_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_req_arbiter.sv
// tcdm_req_arbiter
//   Routes NumReq single-beat memory requests to NumTgt targets. Each requester
//   address is decoded against AddrMap. Requests to different targets are
//   accepted in the same cycle. A round-robin pointer per target picks one
//   requester when several contend for that target. Responses come back one
//   cycle after acceptance. An address that matches no rule is accepted at once
//   and answered with rsp_err_o set.
//
//   AddrMap packing: rule i occupies bits [i*RuleW +: RuleW], where
//   RuleW = 32 + 2*AddrWidth. Each rule is laid out as
//   {idx[31:0], start_addr[AddrWidth-1:0], end_addr[AddrWidth-1:0]}.
//
//   Ports
//     clk_i, rst_i               clock, asynchronous active-high reset
//     req_valid_i/addr/wen/wdata requester lanes (flat, lane r at r*W)
//     req_ready_o                per-requester accept
//     rsp_valid_o/rdata/err      per-requester response, one cycle after accept
//     tgt_valid_o/addr/wen/wdata per-target forwarded request
//     tgt_ready_i, tgt_rdata_i   per-target accept, read data one cycle later
//     conflict_cnt_o             per-target 16-bit saturating contention count
//                                (present only with TCDM_REQ_ARB_STATS_EN)
//
//   Build option: define TCDM_REQ_ARB_STATS_EN to add conflict_cnt_o.
module tcdm_req_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned NumTgt    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NoRules   = 2,
  parameter logic [NoRules*(32+2*AddrWidth)-1:0] AddrMap = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_wen_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [NumReq*DataWidth-1:0]   rsp_rdata_o,
  output logic [NumReq-1:0]             rsp_err_o,
  output logic [NumTgt-1:0]             tgt_valid_o,
  output logic [NumTgt*AddrWidth-1:0]   tgt_addr_o,
  output logic [NumTgt-1:0]             tgt_wen_o,
  output logic [NumTgt*DataWidth-1:0]   tgt_wdata_o,
  input  logic [NumTgt-1:0]             tgt_ready_i,
  input  logic [NumTgt*DataWidth-1:0]   tgt_rdata_i
`ifdef TCDM_REQ_ARB_STATS_EN
  ,
  output logic [NumTgt*16-1:0]          conflict_cnt_o
`endif
);

  localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned TgtW  = (NumTgt > 1) ? $clog2(NumTgt) : 1;
  localparam int unsigned RuleW = 32 + 2 * AddrWidth;

  logic [NumReq-1:0][TgtW-1:0] sel;
  logic [NumReq-1:0]           dec_err;
  logic [NumTgt-1:0]           gnt;
  logic [NumTgt-1:0][IdW-1:0]  gnt_id;
  logic [NumTgt-1:0]           xfer;

  logic [NumTgt-1:0][IdW-1:0]  ptr;
  logic [NumTgt-1:0]           rsp_pend;
  logic [NumTgt-1:0][IdW-1:0]  rsp_id;
  logic [NumTgt-1:0]           lock_vld;
  logic [NumTgt-1:0][IdW-1:0]  lock_id;
  logic [NumReq-1:0]           err_pend;

  // Address decode: later rules overwrite earlier ones, so the highest-numbered
  // matching rule wins.
  always_comb begin
    sel     = '0;
    dec_err = '1;
    for (int unsigned r = 0; r < NumReq; r++) begin
      for (int unsigned i = 0; i < NoRules; i++) begin
        if (req_addr_i[r*AddrWidth +: AddrWidth] >= AddrMap[i*RuleW+AddrWidth +: AddrWidth] &&
            req_addr_i[r*AddrWidth +: AddrWidth] <  AddrMap[i*RuleW +: AddrWidth]) begin
          dec_err[r] = 1'b0;
          sel[r]     = TgtW'(AddrMap[i*RuleW+2*AddrWidth +: 32]);
        end
      end
    end
  end

  // Grant: a target that stalled last cycle keeps its requester while that
  // requester still holds; otherwise round-robin search from ptr.
  always_comb begin
    int unsigned s;
    logic [IdW-1:0] c;
    gnt    = '0;
    gnt_id = '0;
    s      = 0;
    c      = '0;
    for (int unsigned t = 0; t < NumTgt; t++) begin
      if (lock_vld[t] && req_valid_i[lock_id[t]] && !dec_err[lock_id[t]] &&
          sel[lock_id[t]] == TgtW'(t)) begin
        gnt[t]    = 1'b1;
        gnt_id[t] = lock_id[t];
      end else begin
        for (int unsigned k = 0; k < NumReq; k++) begin
          s = ptr[t] + k;
          if (s >= NumReq) s = s - NumReq;
          c = IdW'(s);
          if (!gnt[t] && req_valid_i[c] && !dec_err[c] && sel[c] == TgtW'(t)) begin
            gnt[t]    = 1'b1;
            gnt_id[t] = c;
          end
        end
      end
    end
  end

  assign xfer = gnt & tgt_ready_i;

  always_comb begin
    tgt_valid_o = gnt;
    tgt_addr_o  = '0;
    tgt_wen_o   = '0;
    tgt_wdata_o = '0;
    for (int unsigned t = 0; t < NumTgt; t++) begin
      if (gnt[t]) begin
        tgt_addr_o[t*AddrWidth +: AddrWidth]  = req_addr_i[gnt_id[t]*AddrWidth +: AddrWidth];
        tgt_wen_o[t]                          = req_wen_i[gnt_id[t]];
        tgt_wdata_o[t*DataWidth +: DataWidth] = req_wdata_i[gnt_id[t]*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    req_ready_o = dec_err;
    for (int unsigned r = 0; r < NumReq; r++) begin
      for (int unsigned t = 0; t < NumTgt; t++) begin
        if (xfer[t] && gnt_id[t] == IdW'(r)) req_ready_o[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      rsp_pend <= '0;
      rsp_id   <= '0;
      lock_vld <= '0;
      lock_id  <= '0;
      err_pend <= '0;
    end else begin
      for (int unsigned t = 0; t < NumTgt; t++) begin
        if (xfer[t]) begin
          ptr[t]    <= (gnt_id[t] == IdW'(NumReq - 1)) ? '0 : gnt_id[t] + 1'b1;
          rsp_id[t] <= gnt_id[t];
        end
        rsp_pend[t] <= xfer[t];
        lock_vld[t] <= gnt[t] & ~tgt_ready_i[t];
        lock_id[t]  <= gnt_id[t];
      end
      err_pend <= req_valid_i & dec_err;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      if (err_pend[r]) begin
        rsp_valid_o[r] = 1'b1;
        rsp_err_o[r]   = 1'b1;
      end
      for (int unsigned t = 0; t < NumTgt; t++) begin
        if (rsp_pend[t] && rsp_id[t] == IdW'(r)) begin
          rsp_valid_o[r]                        = 1'b1;
          rsp_rdata_o[r*DataWidth +: DataWidth] = tgt_rdata_i[t*DataWidth +: DataWidth];
        end
      end
    end
  end

`ifdef TCDM_REQ_ARB_STATS_EN
  logic [NumTgt-1:0][15:0] cnt;
  logic [NumTgt-1:0]       contend;

  always_comb begin
    int unsigned n;
    contend = '0;
    n       = 0;
    for (int unsigned t = 0; t < NumTgt; t++) begin
      n = 0;
      for (int unsigned r = 0; r < NumReq; r++) begin
        if (req_valid_i[r] && !dec_err[r] && sel[r] == TgtW'(t)) n = n + 1;
      end
      contend[t] = (n >= 2);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      for (int unsigned t = 0; t < NumTgt; t++) begin
        if (contend[t] && cnt[t] != 16'hFFFF) cnt[t] <= cnt[t] + 16'd1;
      end
    end
  end

  assign conflict_cnt_o = cnt;
`endif

endmodule

// File: tb/tb_tcdm_req_arbiter.sv
// Testbench for tcdm_req_arbiter: directed scenarios with a response scoreboard.
// Map: target 0 = [0x0000,0x1000), target 1 = [0x1000,0x2000).
module tb_tcdm_req_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned NT = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [2*(32+2*AW)-1:0] MAP =
    {32'd1, 32'h0000_1000, 32'h0000_2000, 32'd0, 32'h0000_0000, 32'h0000_1000};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_wen = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [NR*DW-1:0] rsp_rdata;
  logic [NR-1:0]    rsp_err;
  logic [NT-1:0]    tgt_valid;
  logic [NT*AW-1:0] tgt_addr;
  logic [NT-1:0]    tgt_wen;
  logic [NT*DW-1:0] tgt_wdata;
  logic [NT-1:0]    tgt_ready = '1;
  logic [NT*DW-1:0] tgt_rdata;
`ifdef TCDM_REQ_ARB_STATS_EN
  logic [NT*16-1:0] conflict_cnt;
`endif

  tcdm_req_arbiter #(
    .NumReq(NR), .NumTgt(NT), .AddrWidth(AW), .DataWidth(DW),
    .NoRules(2), .AddrMap(MAP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wen_i(req_wen),
    .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .tgt_valid_o(tgt_valid), .tgt_addr_o(tgt_addr), .tgt_wen_o(tgt_wen),
    .tgt_wdata_o(tgt_wdata), .tgt_ready_i(tgt_ready), .tgt_rdata_i(tgt_rdata)
`ifdef TCDM_REQ_ARB_STATS_EN
    , .conflict_cnt_o(conflict_cnt)
`endif
  );

  typedef struct {
    logic [1:0]    r;
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned t, input int c);
    return 32'hA000_0000 | (32'(t) << 24) | 32'(c & 32'h0000_FFFF);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Targets return a cycle-stamped word so responses prove their timing.
  always_comb begin
    tgt_rdata = '0;
    for (int t = 0; t < NT; t++) tgt_rdata[t*DW +: DW] = pat(t, cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    req_valid[r]        = v;
    req_addr[r*AW +: AW] = a;
    req_wen[r]          = w;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic push(input logic [1:0] r, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.r = r; x.due = cyc + 1; x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Response monitor: every requester is compared every cycle; anything not
  // scheduled in the scoreboard must read as all-zero.
  always @(negedge clk) begin
    logic [NR-1:0]    ev;
    logic [NR*DW-1:0] ed;
    logic [NR-1:0]    ee;
    exp_t             x;
    if (mon_en) begin
      ev = '0; ed = '0; ee = '0;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        x = exp_q.pop_front();
        if (x.due < cyc) check_eq("rsp_missed", 64'(x.due), 64'(cyc));
        else begin
          ev[x.r] = 1'b1;
          ed[x.r*DW +: DW] = x.data;
          ee[x.r] = x.err;
        end
      end
      for (int r = 0; r < NR; r++) begin
        check_eq($sformatf("rsp_valid[%0d]", r), 64'(rsp_valid[r]), 64'(ev[r]));
        check_eq($sformatf("rsp_rdata[%0d]", r), 64'(rsp_rdata[r*DW +: DW]), 64'(ed[r*DW +: DW]));
        check_eq($sformatf("rsp_err[%0d]", r), 64'(rsp_err[r]), 64'(ee[r]));
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    mon_en = 1'b1;
    set_req(0, 1'b1, 32'h10, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
`ifdef TCDM_REQ_ARB_STATS_EN
    check_eq("cnt_after_reset", 64'(conflict_cnt), 64'd0);
`endif

    // Decode error
    tick();
    set_req(2, 1'b1, 32'h3000, 1'b0, '0);
    @(negedge clk);
    check_eq("err_ready", 64'(req_ready[2]), 64'd1);
    check_eq("err_tgt_valid", 64'(tgt_valid), 64'd0);
    push(2'd2, '0, 1'b1);
    tick();
    set_req(2, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check_eq("err_tgt_valid_next", 64'(tgt_valid), 64'd0);

    // Stall on target 0; req0 joins mid-stall and must not steal the grant
    tick();
    tgt_ready = 2'b10;
    set_req(1, 1'b1, 32'h4, 1'b1, 32'h5555_0001);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_req(0, 1'b1, 32'h8, 1'b0, 32'h0);
      @(negedge clk);
      check_eq("stall_tvalid", 64'(tgt_valid[0]), 64'd1);
      check_eq("stall_taddr", 64'(tgt_addr[0 +: AW]), 64'h4);
      check_eq("stall_twen", 64'(tgt_wen[0]), 64'd1);
      check_eq("stall_ready1", 64'(req_ready[1]), 64'd0);
      check_eq("stall_ready0", 64'(req_ready[0]), 64'd0);
      tick();
    end
    tgt_ready = 2'b11;
    @(negedge clk);
    check_eq("unstall_ready1", 64'(req_ready[1]), 64'd1);
    check_eq("unstall_wdata", 64'(tgt_wdata[0 +: DW]), 64'h5555_0001);
    push(2'd1, pat(0, cyc + 1), 1'b0);
    tick();
    set_req(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check_eq("after_stall_taddr", 64'(tgt_addr[0 +: AW]), 64'h8);
    check_eq("after_stall_ready0", 64'(req_ready[0]), 64'd1);
    push(2'd0, pat(0, cyc + 1), 1'b0);
    tick();
    set_req(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);

    // Parallel targets
    tick();
    set_req(0, 1'b1, 32'h4, 1'b0, '0);
    set_req(1, 1'b1, 32'h1004, 1'b1, 32'hCAFE);
    @(negedge clk);
    check_eq("par_ready0", 64'(req_ready[0]), 64'd1);
    check_eq("par_ready1", 64'(req_ready[1]), 64'd1);
    check_eq("par_tvalid", 64'(tgt_valid), 64'h3);
    check_eq("par_taddr1", 64'(tgt_addr[AW +: AW]), 64'h1004);
    check_eq("par_twen1", 64'(tgt_wen[1]), 64'd1);
    check_eq("par_twdata1", 64'(tgt_wdata[DW +: DW]), 64'hCAFE);
    push(2'd0, pat(0, cyc + 1), 1'b0);
    push(2'd1, pat(1, cyc + 1), 1'b0);
    tick();
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);

    // Reset while a transfer is being accepted: its response must vanish
    tick();
    set_req(1, 1'b1, 32'h10, 1'b0, '0);
    @(negedge clk);
    check_eq("midrst_ready1", 64'(req_ready[1]), 64'd1);
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    tick();
    rst = 1'b0;
    set_req(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
`ifdef TCDM_REQ_ARB_STATS_EN
    check_eq("cnt_after_midrst", 64'(conflict_cnt), 64'd0);
`endif

    // Round-robin on target 0 from a freshly reset pointer
    tick();
    set_req(0, 1'b1, 32'h10, 1'b1, 32'h1111);
    set_req(1, 1'b1, 32'h10, 1'b1, 32'h2222);
    @(negedge clk);
    check_eq("rr0_ready0", 64'(req_ready[0]), 64'd1);
    check_eq("rr0_ready1", 64'(req_ready[1]), 64'd0);
    check_eq("rr0_wdata", 64'(tgt_wdata[0 +: DW]), 64'h1111);
    push(2'd0, pat(0, cyc + 1), 1'b0);
    tick();
    set_req(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check_eq("rr1_ready1", 64'(req_ready[1]), 64'd1);
    check_eq("rr1_wdata", 64'(tgt_wdata[0 +: DW]), 64'h2222);
    push(2'd1, pat(0, cyc + 1), 1'b0);
    tick();
    set_req(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);

`ifdef TCDM_REQ_ARB_STATS_EN
    // Four requesters contending for target 0 over two stalled cycles
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    tgt_ready = 2'b00;
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 32'h8, 1'b0, '0);
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("cnt0_mid", 64'(conflict_cnt[0 +: 16]), 64'd1);
    tick();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, '0, 1'b0, '0);
    tgt_ready = 2'b11;
    @(negedge clk);
    check_eq("cnt0", 64'(conflict_cnt[0 +: 16]), 64'd2);
    check_eq("cnt1", 64'(conflict_cnt[16 +: 16]), 64'd0);
`endif

    tick();
    tick();
    @(negedge clk);
    #1 mon_en = 1'b0;
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
